// File: rtl/if_stage_pc_unit.sv
// rtl/if_stage_pc_unit.sv - IF stage: PC register, imem address, IF/ID pipeline register
// Optional IF_STALL_COUNTER_EN adds stall_cycles / flush_count performance counters.
module if_stage_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          ADDR_W    = 32,
   parameter int          INSTR_W   = 32,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               PC_write,
   input  logic               IF_ID_write,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               jump,
   input  logic [ADDR_W-1:0]  jump_target,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [ADDR_W-1:0]  IF_ID_pc,
   output logic [ADDR_W-1:0]  IF_ID_pc_plus4,
   output logic [INSTR_W-1:0] IF_ID_instr,
`ifdef IF_STALL_COUNTER_EN
   output logic [31:0]        stall_cycles,
   output logic [15:0]        flush_count,
`endif
   output logic               IF_ID_valid
);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  pc_plus4;
   logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
   logic [ADDR_W-1:0]  ifid_pc4_q, ifid_pc4_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic               redirect;

   assign pc_plus4 = pc_q + ADDR_W'(4);
   assign redirect = branch_taken | jump;

   // Branch beats jump: the branch belongs to the older instruction.
   always_comb begin
      pc_d = pc_q;
      if (branch_taken)
         pc_d = {branch_target[ADDR_W-1:2], 2'b00};
      else if (jump)
         pc_d = {jump_target[ADDR_W-1:2], 2'b00};
      else if (PC_write)
         pc_d = pc_plus4;
   end

   always_comb begin
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      if (redirect) begin
         ifid_pc_d    = '0;
         ifid_pc4_d   = '0;
         ifid_instr_d = INSTR_W'(NOP_INSTR);
         ifid_valid_d = 1'b0;
      end else if (IF_ID_write) begin
         ifid_pc_d    = pc_q;
         ifid_pc4_d   = pc_plus4;
         ifid_instr_d = imem_instr;
         ifid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q         <= ADDR_W'(RESET_PC);
         ifid_pc_q    <= '0;
         ifid_pc4_q   <= '0;
         ifid_instr_q <= INSTR_W'(NOP_INSTR);
         ifid_valid_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_pc4_q   <= ifid_pc4_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
      end
   end

`ifdef IF_STALL_COUNTER_EN
   logic [31:0] stall_q, stall_d;
   logic [15:0] flush_q, flush_d;

   // Counters wrap naturally at all-ones.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (redirect)
         flush_d = flush_q + 16'd1;
      else if (!PC_write)
         stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`endif

   assign imem_addr      = pc_q;
   assign IF_ID_pc       = ifid_pc_q;
   assign IF_ID_pc_plus4 = ifid_pc4_q;
   assign IF_ID_instr    = ifid_instr_q;
   assign IF_ID_valid    = ifid_valid_q;

endmodule
